// File: rtl/router_reg_pipe.sv
// router_reg_pipe: packet register stage between the router input FSM and the
// per-port output FIFOs. Captures and validates the header, forwards header,
// payload and parity bytes to the FIFO write port, absorbs bytes that arrive
// while the FIFO is full in a small skid buffer, and checks packet parity and
// payload length.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rst_int_reg         active-low synchronous clear of low_pkt_valid
//   pkt_valid, din      source byte valid / byte (pkt_valid low on parity byte)
//   fifo_full           selected output FIFO is full
//   detect_add, lfd_state, ld_state, laf_state   one-hot FSM state decodes
//   dout, dout_we       FIFO write data / strobe
//   bad_addr            one-cycle pulse, header address out of range
//   parity_done         parity byte captured (sticky until next header)
//   low_pkt_valid       end of packet seen (cleared by rst_int_reg)
//   err, len_err        parity mismatch / payload length mismatch
//   skid_ovf            a byte was lost because the skid buffer was full
//   skid_cnt            skid buffer occupancy
module router_reg_pipe #(
  parameter int unsigned DW          = 8,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned SKID_DEPTH  = 2,
  parameter int unsigned PARITY_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rst_int_reg,
  input  logic                                pkt_valid,
  input  logic [DW-1:0]                       din,
  input  logic                                fifo_full,
  input  logic                                detect_add,
  input  logic                                lfd_state,
  input  logic                                ld_state,
  input  logic                                laf_state,
  output logic [DW-1:0]                       dout,
  output logic                                dout_we,
  output logic                                bad_addr,
  output logic                                parity_done,
  output logic                                low_pkt_valid,
  output logic                                err,
  output logic                                len_err,
  output logic                                skid_ovf,
  output logic [$clog2(SKID_DEPTH + 1)-1:0]   skid_cnt
);

  localparam int unsigned LEN_W = DW - ADDR_W;
  localparam int unsigned SC_W  = $clog2(SKID_DEPTH + 1);

  // Parity accumulation step: XOR or modulo-2^DW sum.
  function automatic logic [DW-1:0] par_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (PARITY_MODE == 1) return a + b;
    else                  return a ^ b;
  endfunction

  logic [DW-1:0]    header_q, header_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    pkt_parity_q, pkt_parity_d;
  logic             parity_done_q, parity_done_d;
  logic             chk_q, chk_d;
  logic             err_q, err_d;
  logic             len_err_q, len_err_d;
  logic             skid_ovf_q, skid_ovf_d;
  logic             low_pkt_valid_q, low_pkt_valid_d;
  logic             bad_addr_q, bad_addr_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             dout_we_q, dout_we_d;
  logic [DW-1:0]    skid_q [SKID_DEPTH];
  logic [DW-1:0]    skid_d [SKID_DEPTH];
  logic [SC_W-1:0]  skid_cnt_q, skid_cnt_d;

  logic            addr_ok, hdr_ok, hdr_bad;
  logic            par_byte, payload, accept;
  logic            skid_empty, drain_st, pop, direct, push, drop;
  logic [SC_W-1:0] cnt_mid;

  // Byte classification and skid buffer control.
  always_comb begin
    addr_ok    = (32'(din[ADDR_W-1:0]) < NUM_PORTS);
    hdr_ok     = detect_add && pkt_valid && addr_ok;
    hdr_bad    = detect_add && pkt_valid && !addr_ok;
    // parity_done_q marks that this packet's parity byte was already taken
    par_byte   = ld_state && !pkt_valid && !parity_done_q;
    payload    = ld_state && pkt_valid;
    accept     = payload || par_byte;
    skid_empty = (skid_cnt_q == '0);
    // skid keeps draining through detect_add so a new header never strands it
    drain_st   = ld_state || laf_state || detect_add;
    pop        = drain_st && !fifo_full && !skid_empty;
    direct     = accept && !fifo_full && skid_empty;
    push       = accept && (fifo_full || !skid_empty);
    cnt_mid    = skid_cnt_q - SC_W'(pop);
    drop       = push && (cnt_mid == SC_W'(SKID_DEPTH));
  end

  // Next-state logic for all registers.
  always_comb begin
    header_d        = header_q;
    len_d           = len_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    pkt_parity_d    = pkt_parity_q;
    parity_done_d   = parity_done_q;
    chk_d           = 1'b0;
    err_d           = err_q;
    len_err_d       = len_err_q;
    skid_ovf_d      = skid_ovf_q;
    low_pkt_valid_d = low_pkt_valid_q;
    bad_addr_d      = hdr_bad;
    dout_d          = dout_q;
    dout_we_d       = 1'b0;
    skid_d          = skid_q;
    skid_cnt_d      = skid_cnt_q;

    if (hdr_ok) begin
      header_d = din;
      len_d    = din[DW-1:ADDR_W];
    end

    // FIFO write port: header first, then skid head, then a bypassing byte.
    if (lfd_state) begin
      dout_d    = header_q;
      dout_we_d = 1'b1;
    end else if (pop) begin
      dout_d    = skid_q[0];
      dout_we_d = 1'b1;
    end else if (direct) begin
      dout_d    = din;
      dout_we_d = 1'b1;
    end

    // Skid buffer is a shift queue with the head at index 0.
    if (pop) begin
      for (int i = 0; i < int'(SKID_DEPTH) - 1; i++) begin
        skid_d[i] = skid_q[i + 1];
      end
    end
    if (push && !drop) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        if (cnt_mid == SC_W'(i)) skid_d[i] = din;
      end
    end
    skid_cnt_d = cnt_mid + SC_W'(push && !drop);

    if (hdr_ok)         acc_d = '0;
    else if (lfd_state) acc_d = par_f('0, header_q);
    else if (payload)   acc_d = par_f(acc_q, din);

    if (hdr_ok)                        cnt_d = '0;
    else if (payload && cnt_q != '1)   cnt_d = cnt_q + DW'(1);

    if (par_byte) begin
      pkt_parity_d = din;
      chk_d        = 1'b1;
    end

    if (hdr_ok)        parity_done_d = 1'b0;
    else if (par_byte) parity_done_d = 1'b1;

    // Checks run the cycle after the parity byte, once acc/count are final.
    if (hdr_ok) begin
      err_d     = 1'b0;
      len_err_d = 1'b0;
    end else if (chk_q) begin
      err_d     = (acc_q != pkt_parity_q);
      len_err_d = (cnt_q != DW'(len_q));
    end

    if (hdr_ok)    skid_ovf_d = 1'b0;
    else if (drop) skid_ovf_d = 1'b1;

    if (!rst_int_reg)  low_pkt_valid_d = 1'b0;
    else if (par_byte) low_pkt_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      header_q        <= '0;
      len_q           <= '0;
      acc_q           <= '0;
      cnt_q           <= '0;
      pkt_parity_q    <= '0;
      parity_done_q   <= 1'b0;
      chk_q           <= 1'b0;
      err_q           <= 1'b0;
      len_err_q       <= 1'b0;
      skid_ovf_q      <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      bad_addr_q      <= 1'b0;
      dout_q          <= '0;
      dout_we_q       <= 1'b0;
      skid_q          <= '{default: '0};
      skid_cnt_q      <= '0;
    end else begin
      header_q        <= header_d;
      len_q           <= len_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      chk_q           <= chk_d;
      err_q           <= err_d;
      len_err_q       <= len_err_d;
      skid_ovf_q      <= skid_ovf_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      bad_addr_q      <= bad_addr_d;
      dout_q          <= dout_d;
      dout_we_q       <= dout_we_d;
      skid_q          <= skid_d;
      skid_cnt_q      <= skid_cnt_d;
    end
  end

  assign dout          = dout_q;
  assign dout_we       = dout_we_q;
  assign bad_addr      = bad_addr_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
  assign len_err       = len_err_q;
  assign skid_ovf      = skid_ovf_q;
  assign skid_cnt      = skid_cnt_q;

endmodule
